// File: rtl/i2c_byte_ctrl_if.sv
// Byte-command and bit-controller signal bundle for i2c_byte_ctrl.
// Command handshake: a command transfers on a rising clk edge where
// cmd_valid and cmd_ready are both high; cmd_ready is only high while the
// sequencer is idle, and cmd_valid is ignored at every other time.
interface i2c_byte_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_start;
  logic       cmd_stop;
  logic       cmd_read;
  logic       cmd_nack;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       ack_out;
  logic       done;
  logic       err;
  logic       busy;
  logic       bit_en;
  logic       bit_rw;
  logic       bit_w;
  logic       bit_start;
  logic       bit_stop;
  logic       bit_r;
  logic       bit_busy;

  // master: the byte sequencer itself
  modport master (
    input  cmd_valid, cmd_start, cmd_stop, cmd_read, cmd_nack, tx_data,
    input  bit_r, bit_busy,
    output cmd_ready, rx_data, ack_out, done, err, busy,
    output bit_en, bit_rw, bit_w, bit_start, bit_stop
  );

  // slave: command source plus bit-level controller
  modport slave (
    output cmd_valid, cmd_start, cmd_stop, cmd_read, cmd_nack, tx_data,
    output bit_r, bit_busy,
    input  cmd_ready, rx_data, ack_out, done, err, busy,
    input  bit_en, bit_rw, bit_w, bit_start, bit_stop
  );
endinterface

// File: rtl/i2c_byte_ctrl.sv
// Byte-level I2C master sequencer: turns one byte command into START /
// 8 data bits (MSB first) / ACK slot / STOP operations on the bit
// controller, with a watchdog on unresponsive bit operations.
module i2c_byte_ctrl #(
  parameter int unsigned TO_CYCLES = 1023
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  i2c_byte_ctrl_if.master      bus,
  output logic [2:0]           dbg_state_o,
  output logic [1:0]           dbg_phase_o
);
  localparam int WDW = $clog2(TO_CYCLES + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TO_CYCLES - 1);

  typedef enum logic [2:0] {M_IDLE, M_START, M_DATA, M_ACK, M_STOP, M_DONE} main_e;
  // P_PEND waits for the bit controller to go idle; P_ISSUE is the single
  // cycle in which bit_en is high.
  typedef enum logic [1:0] {P_PEND, P_ISSUE, P_WAIT_HI, P_WAIT_LO} phase_e;

  main_e          state_q, state_d, launch_state;
  phase_e         phase_q, phase_d;
  logic [2:0]     cnt_q, cnt_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic [7:0]     tx_q, tx_d, rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
  logic           read_q, read_d, nack_q, nack_d, stop_q, stop_d;
  logic           ack_sh_q, ack_sh_d, ack_out_q, ack_out_d;
  logic           cmd_ready_q, cmd_ready_d, busy_q, busy_d;
  logic           done_q, done_d, err_q, err_d;
  logic           bit_en_q, bit_en_d, bit_rw_q, bit_rw_d, bit_w_q, bit_w_d;
  logic           bit_start_q, bit_start_d, bit_stop_q, bit_stop_d;
  logic           issue, launch, abort;

  // State and registered outputs; reset returns everything to idle values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= M_IDLE;
      phase_q     <= P_PEND;
      cnt_q       <= 3'd7;
      wd_q        <= '0;
      tx_q        <= 8'h00;
      rx_sh_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      read_q      <= 1'b0;
      nack_q      <= 1'b0;
      stop_q      <= 1'b0;
      ack_sh_q    <= 1'b1;
      ack_out_q   <= 1'b1;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      bit_en_q    <= 1'b0;
      bit_rw_q    <= 1'b0;
      bit_w_q     <= 1'b0;
      bit_start_q <= 1'b0;
      bit_stop_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      wd_q        <= wd_d;
      tx_q        <= tx_d;
      rx_sh_q     <= rx_sh_d;
      rx_data_q   <= rx_data_d;
      read_q      <= read_d;
      nack_q      <= nack_d;
      stop_q      <= stop_d;
      ack_sh_q    <= ack_sh_d;
      ack_out_q   <= ack_out_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      bit_en_q    <= bit_en_d;
      bit_rw_q    <= bit_rw_d;
      bit_w_q     <= bit_w_d;
      bit_start_q <= bit_start_d;
      bit_stop_q  <= bit_stop_d;
    end
  end

  // Main sequence and sub-phase stepping. An op is launched one cycle
  // early (when the bit controller is seen idle) so bit_en is a register
  // yet appears in the very first cycle of the op.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    cnt_d        = cnt_q;
    wd_d         = '0;
    tx_d         = tx_q;
    read_d       = read_q;
    nack_d       = nack_q;
    stop_d       = stop_q;
    rx_sh_d      = rx_sh_q;
    ack_sh_d     = ack_sh_q;
    rx_data_d    = rx_data_q;
    ack_out_d    = ack_out_q;
    cmd_ready_d  = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    issue        = 1'b0;
    launch       = 1'b0;
    abort        = 1'b0;
    launch_state = M_IDLE;
    unique case (state_q)
      M_IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          tx_d         = bus.tx_data;
          read_d       = bus.cmd_read;
          nack_d       = bus.cmd_nack;
          stop_d       = bus.cmd_stop;
          cnt_d        = 3'd7;
          busy_d       = 1'b1;
          launch       = 1'b1;
          launch_state = bus.cmd_start ? M_START : M_DATA;
        end else begin
          cmd_ready_d = 1'b1;
        end
      end
      M_DONE: begin
        state_d     = M_IDLE;
        busy_d      = 1'b0;
        cmd_ready_d = 1'b1;
      end
      default: begin
        unique case (phase_q)
          P_PEND: begin
            if (!bus.bit_busy) begin
              phase_d = P_ISSUE;
              issue   = 1'b1;
            end
          end
          // The WAIT_HI budget starts counting at the issue cycle.
          P_ISSUE: begin
            phase_d = P_WAIT_HI;
            wd_d    = wd_q + WDW'(1);
          end
          P_WAIT_HI: begin
            if (bus.bit_busy) phase_d = P_WAIT_LO;
            else if (wd_q == WD_LAST) abort = 1'b1;
            else wd_d = wd_q + WDW'(1);
          end
          P_WAIT_LO: begin
            if (!bus.bit_busy) begin
              launch = 1'b1;
              unique case (state_q)
                M_START: launch_state = M_DATA;
                M_DATA: begin
                  if (read_q) rx_sh_d = {rx_sh_q[6:0], bus.bit_r};
                  if (cnt_q == 3'd0) begin
                    launch_state = M_ACK;
                  end else begin
                    launch_state = M_DATA;
                    cnt_d        = cnt_q - 3'd1;
                  end
                end
                M_ACK: begin
                  if (!read_q) ack_sh_d = bus.bit_r;
                  launch_state = stop_q ? M_STOP : M_DONE;
                end
                default: launch_state = M_DONE;
              endcase
            end else if (wd_q == WD_LAST) begin
              abort = 1'b1;
            end else begin
              wd_d = wd_q + WDW'(1);
            end
          end
        endcase
      end
    endcase
    // Watchdog abort: results are not committed and STOP is skipped.
    if (abort) begin
      state_d = M_DONE;
      phase_d = P_PEND;
      done_d  = 1'b1;
      err_d   = 1'b1;
    end
    if (launch) begin
      state_d = launch_state;
      if (launch_state == M_DONE) begin
        phase_d = P_PEND;
        done_d  = 1'b1;
        if (read_q) rx_data_d = rx_sh_d;
        else        ack_out_d = ack_sh_d;
      end else if (!bus.bit_busy) begin
        phase_d = P_ISSUE;
        issue   = 1'b1;
      end else begin
        phase_d = P_PEND;
      end
    end
  end

  // Bit-controller fields for the op being issued; all zero otherwise.
  always_comb begin
    bit_en_d    = issue;
    bit_rw_d    = 1'b0;
    bit_w_d     = 1'b0;
    bit_start_d = 1'b0;
    bit_stop_d  = 1'b0;
    if (issue) begin
      unique case (state_d)
        M_START: bit_start_d = 1'b1;
        M_STOP:  bit_stop_d  = 1'b1;
        M_DATA: begin
          bit_rw_d = !read_d;
          bit_w_d  = !read_d && tx_d[cnt_d];
        end
        M_ACK: begin
          bit_rw_d = read_d;
          bit_w_d  = read_d && nack_d;
        end
        default: ;
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.ack_out   = ack_out_q;
  assign bus.bit_en    = bit_en_q;
  assign bus.bit_rw    = bit_rw_q;
  assign bus.bit_w     = bit_w_q;
  assign bus.bit_start = bit_start_q;
  assign bus.bit_stop  = bit_stop_q;
  assign dbg_state_o   = state_q;
  assign dbg_phase_o   = phase_q;
endmodule

// File: tb/tb_i2c_byte_ctrl.sv
// Bench for i2c_byte_ctrl: a bit-controller model answers bit ops, a
// reference model predicts op sequences and results, and a monitor
// scores what the DUT actually presents.
module tb_i2c_byte_ctrl;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] dbg_state;
  logic [1:0] dbg_phase;

  i2c_byte_ctrl_if bus ();

  i2c_byte_ctrl #(.TO_CYCLES(TO)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state),
    .dbg_phase_o (dbg_phase)
  );

  // clock / reset block
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [3:0] exp_q[$];       // expected bit ops {start, stop, rw, w}
  logic [9:0] exp_res_q[$];   // expected {err, rx_data, ack_out} at done
  logic [1:0] resp_q[$];      // per-op model response {hang, bit_r}
  int checks = 0;
  int errors = 0;
  int last_en_cyc = 0;
  int last_done_cyc = -100;
  logic [7:0] model_rx = 8'h00;
  logic model_ack = 1'b1;
  bit prev_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference model: op list and final result straight from the byte rules.
  task automatic push_expect(input bit st, input bit sp, input bit rd, input bit nk,
                             input logic [7:0] tx, input bit ackb,
                             input logic [7:0] rdat, input int hang);
    logic [3:0] ops[$];
    logic [1:0] rsp[$];
    if (st) begin ops.push_back(4'b1000); rsp.push_back({1'b0, 1'($urandom_range(0, 1))}); end
    for (int i = 7; i >= 0; i--) begin
      if (rd) begin
        ops.push_back(4'b0000);
        rsp.push_back({1'b0, rdat[i]});
      end else begin
        ops.push_back({3'b001, tx[i]});
        rsp.push_back({1'b0, 1'($urandom_range(0, 1))});
      end
    end
    ops.push_back(rd ? {3'b001, nk} : 4'b0000);
    rsp.push_back({1'b0, rd ? 1'($urandom_range(0, 1)) : ackb});
    if (sp) begin ops.push_back(4'b0100); rsp.push_back({1'b0, 1'($urandom_range(0, 1))}); end
    if (hang > 0) begin
      while (ops.size() > hang) begin
        void'(ops.pop_back());
        void'(rsp.pop_back());
      end
      rsp[hang-1][1] = 1'b1;
    end
    foreach (ops[i]) exp_q.push_back(ops[i]);
    foreach (rsp[i]) resp_q.push_back(rsp[i]);
    if (hang > 0) exp_res_q.push_back({1'b1, model_rx, model_ack});
    else exp_res_q.push_back({1'b0, rd ? rdat : model_rx, rd ? model_ack : ackb});
  endtask

  // Ideal bit controller: busy rises one cycle after bit_en, stays high N
  // cycles; a hang entry leaves busy low forever for that op.
  logic [1:0] model_r;
  initial begin
    bus.bit_busy = 1'b0;
    bus.bit_r = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.bit_en) begin
        model_r = (resp_q.size() != 0) ? resp_q.pop_front() : 2'b00;
        if (!model_r[1]) begin
          @(posedge clk); #1;
          bus.bit_busy = 1'b1;
          bus.bit_r = model_r[0];
          repeat ($urandom_range(1, 4)) @(posedge clk);
          #1 bus.bit_busy = 1'b0;
        end
      end
    end
  end

  // Monitor: scores bit ops and completions as the DUT presents them.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_done = 1'b0;
    end else begin
      if (prev_done) begin
        chk("ready_after_done", bus.cmd_ready, 1);
        chk("idle_after_done", bus.busy, 0);
      end
      prev_done = bus.done;
      if (bus.bit_en) begin
        last_en_cyc = cyc;
        chk("en_while_busy", bus.bit_busy, 0);
        chk("start_and_stop", bus.bit_start & bus.bit_stop, 0);
        chk("rx_stable", bus.rx_data, model_rx);
        chk("op_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0)
          chk("bit_op", {bus.bit_start, bus.bit_stop, bus.bit_rw, bus.bit_w}, exp_q.pop_front());
      end
      if (bus.done) begin
        last_done_cyc = cyc;
        chk("done_expected", exp_res_q.size() != 0, 1);
        chk("ops_complete", exp_q.size(), 0);
        if (exp_res_q.size() != 0) begin
          logic [9:0] r;
          r = exp_res_q.pop_front();
          chk("result", {bus.err, bus.rx_data, bus.ack_out}, r);
          model_rx = r[8:1];
          model_ack = r[0];
        end
      end
    end
  end

  // driver tasks
  task automatic set_fields(input bit st, input bit sp, input bit rd, input bit nk, input logic [7:0] tx);
    bus.cmd_start = st;
    bus.cmd_stop = sp;
    bus.cmd_read = rd;
    bus.cmd_nack = nk;
    bus.tx_data = tx;
  endtask

  task automatic run_cmd(input bit st, input bit sp, input bit rd, input bit nk,
                         input logic [7:0] tx, input bit ackb,
                         input logic [7:0] rdat, input int hang);
    bit ok = 1'b0;
    @(posedge clk); #1;
    set_fields(st, sp, rd, nk, tx);
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin ok = 1'b1; break; end
    end
    chk("accept", ok, 1);
    if (ok) push_expect(st, sp, rd, nk, tx, ackb, rdat, hang);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int i = 0;
    while (exp_res_q.size() != 0 && i < 600) begin
      @(negedge clk);
      i++;
    end
    chk({name, "_complete"}, exp_res_q.size(), 0);
    if (exp_res_q.size() != 0) begin
      exp_res_q.delete();
      exp_q.delete();
      resp_q.delete();
    end
    @(negedge clk);
  endtask

  // stimulus
  initial begin
    bit st, sp, rd, nk, ab;
    logic [7:0] tx, rdat;
    int hang, seen;
    bit b_st[3], b_sp[3], b_rd[3], b_nk[3], b_ab[3];
    logic [7:0] b_tx[3], b_rdat[3];

    bus.cmd_valid = 1'b0;
    set_fields(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    #23;
    chk("reset_outputs",
        {bus.cmd_ready, bus.busy, bus.done, bus.err, bus.rx_data, bus.ack_out,
         bus.bit_en, bus.bit_rw, bus.bit_w, bus.bit_start, bus.bit_stop},
        {4'b0000, 8'h00, 1'b1, 5'b00000});
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", bus.cmd_ready, 1);

    // write 0xA5 with START/STOP, slave ACKs
    run_cmd(1, 1, 0, 0, 8'hA5, 1'b0, 8'h00, 0);
    wait_idle("write_a5");
    // read 0x3C, no START/STOP, master NACKs
    run_cmd(0, 0, 1, 1, 8'h00, 1'b0, 8'h3C, 0);
    wait_idle("read_3c");
    // write 0x00, slave NACKs, STOP still issued
    run_cmd(1, 1, 0, 0, 8'h00, 1'b1, 8'h00, 0);
    wait_idle("write_nack");
    // bit controller hangs on the 3rd op
    run_cmd(1, 1, 0, 0, 8'h5A, 1'b0, 8'h00, 3);
    wait_idle("hang");
    chk("timeout_latency", last_done_cyc - last_en_cyc, TO);

    // three back-to-back commands with cmd_valid held high
    for (int k = 0; k < 3; k++) begin
      b_st[k] = 1'($urandom_range(0, 1)); b_sp[k] = 1'($urandom_range(0, 1));
      b_rd[k] = 1'($urandom_range(0, 1)); b_nk[k] = 1'($urandom_range(0, 1));
      b_ab[k] = 1'($urandom_range(0, 1));
      b_tx[k] = 8'($urandom_range(0, 255)); b_rdat[k] = 8'($urandom_range(0, 255));
    end
    @(posedge clk); #1;
    set_fields(b_st[0], b_sp[0], b_rd[0], b_nk[0], b_tx[0]);
    bus.cmd_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bit ok = 1'b0;
      for (int i = 0; i < 600; i++) begin
        @(negedge clk);
        if (bus.cmd_ready) begin ok = 1'b1; break; end
      end
      chk("b2b_accept", ok, 1);
      if (k > 0) chk("b2b_gap", cyc - last_done_cyc, 1);
      push_expect(b_st[k], b_sp[k], b_rd[k], b_nk[k], b_tx[k], b_ab[k], b_rdat[k], 0);
      @(posedge clk); #1;
      if (k < 2) set_fields(b_st[k+1], b_sp[k+1], b_rd[k+1], b_nk[k+1], b_tx[k+1]);
      else bus.cmd_valid = 1'b0;
    end
    wait_idle("b2b");

    // reset during the 4th data bit (5th op with START)
    run_cmd(1, 1, 0, 0, 8'hC3, 1'b0, 8'h00, 0);
    seen = 0;
    for (int i = 0; i < 300 && seen < 5; i++) begin
      @(negedge clk);
      if (bus.bit_en) seen++;
    end
    chk("reach_data_bit4", seen, 5);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_bit_en", bus.bit_en, 0);
    chk("rst_mid_outputs",
        {bus.cmd_ready, bus.busy, bus.done, bus.err, bus.rx_data, bus.ack_out,
         bus.bit_rw, bus.bit_w, bus.bit_start, bus.bit_stop},
        {4'b0000, 8'h00, 1'b1, 4'b0000});
    repeat (8) @(posedge clk);
    exp_q.delete();
    exp_res_q.delete();
    resp_q.delete();
    model_rx = 8'h00;
    model_ack = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_mid_reset", bus.cmd_ready, 1);
    run_cmd(1, 1, 0, 0, 8'h96, 1'b0, 8'h00, 0);
    wait_idle("after_reset");

    // randomized commands
    for (int n = 0; n < 20; n++) begin
      st = 1'($urandom_range(0, 1)); sp = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1)); nk = 1'($urandom_range(0, 1));
      ab = 1'($urandom_range(0, 1));
      tx = 8'($urandom_range(0, 255)); rdat = 8'($urandom_range(0, 255));
      hang = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 9)) : 0;
      run_cmd(st, sp, rd, nk, tx, ab, rdat, hang);
      wait_idle("random");
      if (hang > 0) chk("random_timeout_latency", last_done_cyc - last_en_cyc, TO);
    end

    repeat (3) @(negedge clk);
    chk("ops_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t, required to finish", $time);
    $fatal(1);
  end
endmodule

// File: doc/i2c_byte_ctrl.md
# i2c_byte_ctrl

Byte-level I2C master sequencer that sits directly above the bit-level bus controller and drives its `en`/`rw`/`w_bit`/`start_cond`/`stop_cond` inputs. It accepts one byte command at a time from the position-sensor readout logic, optionally preceded by START and followed by STOP. It then issues the bit operations in order (8 data bits MSB first plus the ACK slot), collects read data and the slave ACK, and reports completion with a single-cycle `done` pulse. A watchdog flags a bit controller that never responds.

## Interface
- `TO_CYCLES`, 1023: max clk cycles spent in WAIT_HI or WAIT_LO before abort.
- `clk` in 1: system clock, all logic on posedge.
- `rst` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: high only in IDLE; a command is accepted when `cmd_valid & cmd_ready`.
- `cmd_start` in 1: generate START before the byte.
- `cmd_stop` in 1: generate STOP after the ACK slot.
- `cmd_read` in 1: 1 = read byte, 0 = write byte.
- `cmd_nack` in 1: read only; 1 = master sends NACK (SDA released), 0 = ACK.
- `tx_data` in 8: write byte, latched at accept.
- `rx_data` out 8: read byte, valid from `done` until the next accept.
- `ack_out` out 1: write only; sampled slave ACK bit (0 = ACK).
- `done` out 1: one-cycle pulse at end of command.
- `err` out 1: one-cycle pulse with `done` on watchdog abort.
- `busy` out 1: high from accept through the `done` cycle.
- `bit_en`, `bit_rw`, `bit_w`, `bit_start`, `bit_stop` out 1 each: to bit controller.
- `bit_r` in 1: bit controller read bit.
- `bit_busy` in 1: bit controller busy.

## Operation
- Reset values: `cmd_ready`=0 in RESET then 1, `busy`=0, `done`=0, `err`=0, `rx_data`=0x00, `ack_out`=1, all `bit_*` outputs=0. All outputs are registered.
- Main FSM: IDLE → (START if `cmd_start`) → DATA ×8 → ACK → (STOP if `cmd_stop`) → DONE → IDLE.
- On accept, latch `tx_data`, `cmd_read`, `cmd_nack`, `cmd_stop` into shadow regs; `cmd_start` selects the first state. The bit counter loads 7.
- Each non-IDLE/DONE state runs a sub-phase ISSUE → WAIT_HI → WAIT_LO:
  - ISSUE: when `bit_busy`=0, assert `bit_en` for exactly one cycle with `bit_rw`/`bit_w`/`bit_start`/`bit_stop` valid the same cycle, then go to WAIT_HI.
  - WAIT_HI: wait for `bit_busy`=1.
  - WAIT_LO: wait for `bit_busy`=0. In that cycle, capture `bit_r` if needed and advance the main FSM.
- Per-state bit fields:
  - START: `bit_start`=1.
  - STOP: `bit_stop`=1.
  - DATA write: `bit_rw`=1, `bit_w`=tx[cnt].
  - DATA read: `bit_rw`=0, shift `bit_r` into rx LSB.
  - ACK write: `bit_rw`=0, `ack_out` ← `bit_r`.
  - ACK read: `bit_rw`=1, `bit_w`=`cmd_nack`.
- `bit_start`/`bit_stop` are 0 whenever `bit_en`=0. `bit_start` and `bit_stop` are never both 1.
- Bit counter decrements after each DATA bit and wraps 0 → ACK. There is no 9th DATA op.
- `rx_data` output updates only in DONE, never with a partial byte.
- Watchdog: a counter resets on each sub-phase entry. If it reaches `TO_CYCLES` in WAIT_HI/WAIT_LO, the FSM goes to DONE with `err`=1. STOP is not issued, and `rx_data`/`ack_out` keep their old values.
- `cmd_valid` outside IDLE is ignored. The input may stay high; a new command is accepted the cycle after DONE.
- Reset asserted mid-command: immediate return to reset values. `bit_en` drops asynchronously and no `done` pulse is issued.

## Timing
- Accept at cycle 0 → `bit_en` earliest at cycle 1 (ISSUE, `bit_busy`=0).
- Per bit op: 1 ISSUE cycle + WAIT_HI + WAIT_LO. With an ideal bit controller (`busy` high 1 cycle after `en`, low N cycles later), each op takes N+2 cycles.
- Op count per command: 9 + `cmd_start` + `cmd_stop` (max 11).
- `done` rises the cycle after the last WAIT_LO completion. `cmd_ready` rises the cycle after `done`.
- `bit_en` is never asserted while `bit_busy`=1 and is never asserted twice for one op.

## Test plan
- Write 0xA5, start=1, stop=1, bit-controller model returns `bit_r`=0 on the ACK op:
  - 11 `bit_en` pulses in order: start, w 1,0,1,0,0,1,0,1, read, stop.
  - `ack_out`=0, `done` once, `err`=0.
- Read, start=0, stop=0, nack=1, model returns 0x3C MSB first:
  - 9 ops; the ACK op has `bit_rw`=1, `bit_w`=1.
  - `rx_data`=0x3C at `done`; `rx_data` is unchanged before `done`.
- Write 0x00 where the slave returns `bit_r`=1 on ACK → `ack_out`=1, `done` pulse, STOP still issued when `cmd_stop`=1.
- Model holds `bit_busy`=0 after the 3rd `bit_en` (`TO_CYCLES`=16):
  - `done` and `err` pulse together 16 cycles later.
  - No STOP is issued; `cmd_ready`=1 on the next cycle.
- `cmd_valid` held high for 3 back-to-back commands → each accepted exactly one cycle after the previous `done`; no command is lost or duplicated.
- `rst` pulled low during DATA bit 4 → all outputs at reset values within the same cycle. A fresh write after release completes normally.
